// File: rtl/wb_slave_mem.sv
// Wishbone classic-cycle slave RAM with programmable wait states,
// address range/alignment error and optional periodic retry.
module wb_slave_mem #(
   parameter int unsigned    DW          = 32,
   parameter int unsigned    AW          = 32,
   parameter int unsigned    MEM_WORDS   = 1024,
   parameter logic [AW-1:0]  BASE_ADDR   = '0,
   parameter int unsigned    WAIT_STATES = 1,
   parameter int unsigned    RTY_EVERY   = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   wb_addr_i,
   input  logic [DW-1:0]   wb_data_i,
   input  logic [DW/8-1:0] wb_sel_i,
   input  logic            wb_we_i,
   input  logic            wb_cyc_i,
   input  logic            wb_stb_i,
   output logic [DW-1:0]   wb_data_o,
   output logic            wb_ack_o,
   output logic            wb_err_o,
   output logic            wb_rty_o
);

   localparam int SW  = DW / 8;
   localparam int LSB = $clog2(SW);
   localparam int IW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int RW  = (RTY_EVERY > 0) ? $clog2(RTY_EVERY + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ACK,
      S_ERR,
      S_RTY
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      wcnt_q, wcnt_d;
   logic [RW-1:0]   rcnt_q, rcnt_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [DW-1:0]   wdat_q, wdat_d;
   logic [SW-1:0]   sel_q, sel_d;
   logic            we_q, we_d;
   logic [DW-1:0]   rdata_q, rdata_d;

   logic [DW-1:0]   mem [MEM_WORDS];

   logic            req;
   logic [AW-1:0]   off;
   logic [AW-1:0]   woff;
   logic            bad;

   logic            acc;
   logic [IW-1:0]   a_idx;
   logic [DW-1:0]   a_dat;
   logic [SW-1:0]   a_sel;
   logic            a_we;

   assign req  = wb_cyc_i & wb_stb_i;
   assign off  = wb_addr_i - BASE_ADDR;
   assign woff = off >> LSB;
   assign bad  = (wb_addr_i < BASE_ADDR)
               | ((off & AW'(SW - 1)) != '0)
               | (woff >= AW'(MEM_WORDS));

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      rcnt_d  = rcnt_q;
      idx_d   = idx_q;
      wdat_d  = wdat_q;
      sel_d   = sel_q;
      we_d    = we_q;
      rdata_d = '0;
      acc     = 1'b0;
      a_idx   = idx_q;
      a_dat   = wdat_q;
      a_sel   = sel_q;
      a_we    = we_q;
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               if (bad) begin
                  state_d = S_ERR;
               end else begin
                  idx_d  = woff[IW-1:0];
                  wdat_d = wb_data_i;
                  sel_d  = wb_sel_i;
                  we_d   = wb_we_i;
                  if (RTY_EVERY > 0 &&
                      rcnt_q == RW'(RTY_EVERY - 1)) begin
                     rcnt_d  = '0;
                     state_d = S_RTY;
                  end else begin
                     if (RTY_EVERY > 0) rcnt_d = rcnt_q + RW'(1);
                     if (WAIT_STATES == 0) begin
                        state_d = S_ACK;
                        acc     = 1'b1;
                        a_idx   = woff[IW-1:0];
                        a_dat   = wb_data_i;
                        a_sel   = wb_sel_i;
                        a_we    = wb_we_i;
                     end else begin
                        state_d = S_WAIT;
                        wcnt_d  = 4'(WAIT_STATES - 1);
                     end
                  end
               end
            end
         end
         S_WAIT: begin
            if (!req) begin
               state_d = S_IDLE;
            end else if (wcnt_q == 4'd0) begin
               state_d = S_ACK;
               acc     = 1'b1;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         S_ACK, S_ERR, S_RTY: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (acc && !a_we) rdata_d = mem[a_idx];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         wcnt_q  <= '0;
         rcnt_q  <= '0;
         idx_q   <= '0;
         wdat_q  <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         rcnt_q  <= rcnt_d;
         idx_q   <= idx_d;
         wdat_q  <= wdat_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
      end
   end

   // RAM is not reset; a write is suppressed while reset is held
   always_ff @(posedge clk) begin
      if (!rst && acc && a_we) begin
         for (int i = 0; i < SW; i++) begin
            if (a_sel[i]) mem[a_idx][8*i +: 8] <= a_dat[8*i +: 8];
         end
      end
   end

   assign wb_data_o = rdata_q;
   assign wb_ack_o  = (state_q == S_ACK);
   assign wb_err_o  = (state_q == S_ERR);
   assign wb_rty_o  = (state_q == S_RTY);

endmodule
